// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin write-port arbiter that shares one FIFO write side
// between NUM_REQ producers. A producer is granted for a burst of up to MAX_BURST
// words. The burst ends early when the producer drops req. While the FIFO is full
// the burst stalls.
//
// Optional feature (macro WATERMARK_EN): a burst is started only when the FIFO has
// room for a full MAX_BURST words, so a burst never stalls on full.
//
// Ports:
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   req_i          per-producer word valid, held until acked
//   req_data_i     producer i data in [i*DATA_W +: DATA_W]
//   ack_o          one-hot pulse, granted producer's word written this cycle
//   grant_o        one-hot current owner, zero when idle
//   fifo_full_i    FIFO full flag
//   fifo_counter_i FIFO occupancy (used only with WATERMARK_EN)
//   fifo_wr_en_o   FIFO write enable
//   fifo_din_o     FIFO write data, zero when not writing
//   busy_o         high while a burst is in progress
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned MAX_BURST  = 4,
    parameter int unsigned FIFO_DEPTH = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    output logic [NUM_REQ-1:0]        ack_o,
    output logic [NUM_REQ-1:0]        grant_o,
    input  logic                      fifo_full_i,
    input  logic [6:0]                fifo_counter_i,
    output logic                      fifo_wr_en_o,
    output logic [DATA_W-1:0]         fifo_din_o,
    output logic                      busy_o
);

    localparam int unsigned CntW = $clog2(MAX_BURST + 1);
    localparam int unsigned PtrW = $clog2(NUM_REQ);

    typedef enum logic [0:0] {StArb, StBurst} state_e;

    state_e              state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [PtrW-1:0]     gidx_q, gidx_d;
    logic [PtrW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [CntW-1:0]     cnt_inc;
    logic [PtrW-1:0]     sel_idx;
    logic [PtrW-1:0]     gidx_next;
    logic                sel_found;
    logic                wr_en;
    logic                start_ok;
    logic                space_ok;
    int                  free_space;
    int unsigned         scan_idx;

    // Free FIFO slots; signed so an out-of-range occupancy cannot wrap to "plenty".
    assign free_space = int'(FIFO_DEPTH) - int'(fifo_counter_i);
    assign space_ok   = free_space >= int'(MAX_BURST);

`ifdef WATERMARK_EN
    assign start_ok = space_ok;
`else
    logic unused_space;
    assign start_ok     = 1'b1;
    assign unused_space = space_ok;
`endif

    // First requester at or after rr_ptr_q, wrapping modulo NUM_REQ.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        scan_idx  = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            scan_idx = 32'(rr_ptr_q) + i;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            if (!sel_found && req_i[scan_idx[PtrW-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = scan_idx[PtrW-1:0];
            end
        end
    end

    assign gidx_next = (gidx_q == PtrW'(NUM_REQ - 1)) ? '0 : gidx_q + PtrW'(1);
    assign cnt_inc   = cnt_q + CntW'(1);

    // Write path is combinational from the registered grant.
    assign wr_en        = (state_q == StBurst) && req_i[gidx_q] && !fifo_full_i;
    assign fifo_wr_en_o = wr_en;
    assign ack_o        = wr_en ? grant_q : '0;
    assign grant_o      = grant_q;
    assign busy_o       = (state_q == StBurst);

    always_comb begin
        fifo_din_o = '0;
        if (wr_en) begin
            fifo_din_o = req_data_i[32'(gidx_q) * DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        gidx_d   = gidx_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            StArb: begin
                if (sel_found && start_ok) begin
                    state_d          = StBurst;
                    grant_d          = '0;
                    grant_d[sel_idx] = 1'b1;
                    gidx_d           = sel_idx;
                    cnt_d            = '0;
                end
            end
            StBurst: begin
                if (wr_en) begin
                    cnt_d = cnt_inc;
                end
                // A full FIFO with req still high simply holds everything.
                if ((wr_en && (cnt_inc == CntW'(MAX_BURST))) || !req_i[gidx_q]) begin
                    state_d  = StArb;
                    grant_d  = '0;
                    rr_ptr_d = gidx_next;
                end
            end
            default: state_d = StArb;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StArb;
            grant_q  <= '0;
            gidx_q   <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            gidx_q   <= gidx_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a simple FIFO occupancy model and
// per-producer word counters drive the DUT; each scenario task checks inline.
module tb_fifo_wr_arbiter;

    localparam int NR = 4;

    logic          clk;
    logic          rst_n;
    logic [3:0]    req;
    logic [31:0]   req_data;
    logic [3:0]    ack;
    logic [3:0]    grant;
    logic          fifo_full;
    logic [6:0]    fifo_cnt;
    logic          fifo_wr_en;
    logic [7:0]    fifo_din;
    logic          busy;

    int            rem [NR];
    logic [7:0]    data [NR];

    logic [3:0]    o_grant;
    logic [3:0]    o_ack;
    logic          o_wr;
    logic [7:0]    o_din;
    logic          o_busy;

    int checks;
    int failures;

    fifo_wr_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_i          (req),
        .req_data_i     (req_data),
        .ack_o          (ack),
        .grant_o        (grant),
        .fifo_full_i    (fifo_full),
        .fifo_counter_i (fifo_cnt),
        .fifo_wr_en_o   (fifo_wr_en),
        .fifo_din_o     (fifo_din),
        .busy_o         (busy)
    );

    assign fifo_full = (fifo_cnt >= 7'd64);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            req[i]             = (rem[i] != 0);
            req_data[i*8 +: 8] = data[i];
        end
    endtask

    // Sample outputs at negedge, then advance past the next rising edge and
    // update the FIFO and producer models from what was sampled.
    task automatic tick();
        @(negedge clk);
        o_grant = grant;
        o_ack   = ack;
        o_wr    = fifo_wr_en;
        o_din   = fifo_din;
        o_busy  = busy;
        @(posedge clk);
        #1;
        if (o_wr) fifo_cnt = fifo_cnt + 7'd1;
        for (int i = 0; i < NR; i++) begin
            if (o_ack[i]) begin
                rem[i]  = rem[i] - 1;
                data[i] = data[i] + 8'd1;
            end
        end
        drive();
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        fifo_cnt = 7'd0;
        for (int i = 0; i < NR; i++) begin
            rem[i]  = 0;
            data[i] = 8'h00;
        end
        drive();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        fifo_cnt = 7'd0;
        for (int i = 0; i < NR; i++) begin
            rem[i]  = 1;
            data[i] = 8'hA0 + 8'(i);
        end
        drive();
        @(posedge clk);
        #1;
        checks++;
        if (grant !== 4'b0 || ack !== 4'b0 || fifo_wr_en !== 1'b0 || busy !== 1'b0
            || fifo_din !== 8'h00) begin
            failures++;
            $display("FAIL reset_outputs: grant=%b ack=%b wr=%b busy=%b din=%h required all 0",
                     grant, ack, fifo_wr_en, busy, fifo_din);
        end
        do_reset();
    endtask

    task automatic test_single();
        logic [3:0] eg [7] = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0001};
        logic [7:0] ed [7] = '{8'h00, 8'h10, 8'h11, 8'h12, 8'h13, 8'h00, 8'h14};
        do_reset();
        rem[0]  = 8;
        data[0] = 8'h10;
        drive();
        for (int c = 0; c < 7; c++) begin
            tick();
            checks++;
            if (o_grant !== eg[c] || o_wr !== (eg[c] != 0) || o_din !== ed[c]) begin
                failures++;
                $display("FAIL single_c%0d: grant=%b wr=%b din=%h required grant=%b din=%h",
                         c, o_grant, o_wr, o_din, eg[c], ed[c]);
            end
            if (c == 5) begin
                checks++;
                if (fifo_cnt !== 7'd4 || o_busy !== 1'b0) begin
                    failures++;
                    $display("FAIL single_count: fifo_cnt=%0d busy=%b required 4 and 0",
                             fifo_cnt, o_busy);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] eg;
        logic       ew;
        logic [7:0] ed;
        int b;
        int pos;
        do_reset();
        for (int i = 0; i < NR; i++) begin
            rem[i]  = 100;
            data[i] = 8'(i * 32);
        end
        drive();
        for (int c = 0; c < 22; c++) begin
            eg = 4'b0;
            ew = 1'b0;
            ed = 8'h00;
            if (c > 0) begin
                b   = (c - 1) / 5;
                pos = (c - 1) % 5;
                if (pos < 4) begin
                    eg = 4'b0001 << (b % 4);
                    ew = 1'b1;
                    ed = 8'((b % 4) * 32 + (b / 4) * 4 + pos);
                end
            end
            tick();
            checks++;
            if (o_grant !== eg || o_wr !== ew || o_din !== ed || o_ack !== (ew ? eg : 4'b0)) begin
                failures++;
                $display("FAIL rr_c%0d: grant=%b ack=%b din=%h required grant=%b din=%h wr=%b",
                         c, o_grant, o_ack, o_din, eg, ed, ew);
            end
        end
    endtask

    task automatic test_early_drop();
        int acks2;
        logic [3:0] exp5;
        for (int sub = 0; sub < 2; sub++) begin
            do_reset();
            rem[2] = 2;
            rem[3] = (sub == 0) ? 4 : 0;
            exp5   = (sub == 0) ? 4'b1000 : 4'b0001;
            drive();
            acks2 = 0;
            for (int c = 0; c < 6; c++) begin
                tick();
                if (o_ack[2]) acks2++;
                if (c == 2) begin
                    rem[0] = 1;
                    drive();
                end
                if (c == 3) begin
                    checks++;
                    if (o_grant !== 4'b0100 || o_wr !== 1'b0) begin
                        failures++;
                        $display("FAIL drop_end%0d: grant=%b wr=%b required 0100 and 0",
                                 sub, o_grant, o_wr);
                    end
                end
            end
            checks++;
            if (acks2 !== 2) begin
                failures++;
                $display("FAIL drop_acks%0d: acks=%0d required 2", sub, acks2);
            end
            checks++;
            if (o_grant !== exp5) begin
                failures++;
                $display("FAIL drop_next%0d: grant=%b required %b", sub, o_grant, exp5);
            end
        end
    endtask

    task automatic test_full_stall();
        logic [3:0] eg [9] = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0};
        logic       ew [9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [7:0] ed [9] = '{8'h00, 8'h50, 8'h51, 8'h00, 8'h00, 8'h52, 8'h00, 8'h53, 8'h00};
        logic       rd [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        do_reset();
        fifo_cnt = 7'd62;
        rem[1]   = 10;
        data[1]  = 8'h50;
        drive();
        for (int c = 0; c < 9; c++) begin
            if (rd[c]) fifo_cnt = fifo_cnt - 7'd1;
            tick();
            checks++;
            if (o_grant !== eg[c] || o_wr !== ew[c] || o_din !== ed[c]
                || o_ack !== (ew[c] ? eg[c] : 4'b0)) begin
                failures++;
                $display("FAIL full_c%0d: grant=%b wr=%b ack=%b din=%h required grant=%b wr=%b din=%h",
                         c, o_grant, o_wr, o_ack, o_din, eg[c], ew[c], ed[c]);
            end
        end
        checks++;
        if (rem[1] !== 6 || fifo_cnt !== 7'd64) begin
            failures++;
            $display("FAIL full_total: words=%0d fifo_cnt=%0d required 4 and 64",
                     10 - rem[1], fifo_cnt);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        rem[0]  = 4;
        rem[2]  = 10;
        data[2] = 8'h70;
        drive();
        for (int c = 0; c < 7; c++) tick();
        checks++;
        if (o_grant !== 4'b0100 || o_wr !== 1'b1 || o_din !== 8'h70) begin
            failures++;
            $display("FAIL arst_pre: grant=%b wr=%b din=%h required 0100 1 70",
                     o_grant, o_wr, o_din);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (grant !== 4'b0 || ack !== 4'b0 || fifo_wr_en !== 1'b0 || busy !== 1'b0
            || fifo_din !== 8'h00) begin
            failures++;
            $display("FAIL arst_now: grant=%b ack=%b wr=%b busy=%b din=%h required all 0",
                     grant, ack, fifo_wr_en, busy, fifo_din);
        end
        @(posedge clk);
        #1;
        checks++;
        if (fifo_wr_en !== 1'b0 || grant !== 4'b0) begin
            failures++;
            $display("FAIL arst_hold: wr=%b grant=%b required 0 and 0000", fifo_wr_en, grant);
        end
        rst_n = 1'b1;
        for (int i = 0; i < NR; i++) rem[i] = 0;
        rem[0] = 1;
        rem[1] = 1;
        drive();
        tick();
        tick();
        checks++;
        if (o_grant !== 4'b0001) begin
            failures++;
            $display("FAIL arst_restart: grant=%b required 0001", o_grant);
        end
    endtask

    task automatic test_watermark();
        do_reset();
        fifo_cnt = 7'd61;
        rem[0]   = 8;
        data[0]  = 8'h10;
        drive();
`ifdef WATERMARK_EN
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (o_grant !== 4'b0 || o_busy !== 1'b0) begin
                failures++;
                $display("FAIL wm_wait%0d: grant=%b busy=%b required 0000 0", c, o_grant, o_busy);
            end
        end
        fifo_cnt = 7'd60;
        tick();
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (o_grant !== 4'b0001 || o_wr !== 1'b1 || o_din !== 8'(8'h10 + c)) begin
                failures++;
                $display("FAIL wm_burst%0d: grant=%b wr=%b din=%h required 0001 1 %h",
                         c, o_grant, o_wr, o_din, 8'(8'h10 + c));
            end
        end
`else
        tick();
        tick();
        checks++;
        if (o_grant !== 4'b0001 || o_wr !== 1'b1 || o_din !== 8'h10) begin
            failures++;
            $display("FAIL nowm_start: grant=%b wr=%b din=%h required 0001 1 10",
                     o_grant, o_wr, o_din);
        end
`endif
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        req      = 4'b0;
        req_data = 32'b0;
        fifo_cnt = 7'd0;
        test_reset();
        test_single();
        test_round_robin();
        test_early_drop();
        test_full_stall();
        test_async_reset();
        test_watermark();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
